// File: rtl/pf_ddr4_dqsw_training_ctrl.sv
// pf_ddr4_dqsw_training_ctrl
//   DQS write-leveling tap search for one DDR4 byte lane. Restores the IOD
//   delay line to tap 0, then at each tap sends SAMPLE_COUNT DQS pulses,
//   majority-votes the DQ feedback, and steps the tap until the first 0->1
//   transition is found. That tap is reported in TAP_RESULT.
//
//   Ports:
//     FAB_CLK, RESET                 fabric clock, async active-high reset
//     TRAIN_START                    one-cycle start pulse (accepted in IDLE)
//     TRAIN_BUSY/DONE/FAIL           status; DONE and FAIL are sticky
//     TAP_RESULT[7:0]                tap of the 0->1 transition, 0 after FAIL
//     TX_DATA_0/OE_DATA_0[1:0]       DQS pattern and output enable to the IOD
//     RX_DATA_0[1:0]                 DQ feedback, bit 0 used
//     DELAY_LINE_LOAD_0/MOVE_0       one-cycle delay-line control pulses
//     DELAY_LINE_DIRECTION_0         always 0 (increment)
//     DELAY_LINE_OUT_OF_RANGE_0      IOD overflow, aborts training
//
//   Optional build macro PF_DDR4_DQSW_PULSE_CNT_EN adds PULSE_COUNT[15:0], a
//   saturating count of PULSE cycles since the last accepted start.
//
//   state   | meaning
//   IDLE    | waiting for TRAIN_START
//   LOAD    | DELAY_LINE_LOAD_0 pulse, restore tap 0
//   SETTLE  | wait SETTLE_CYCLES after load/move
//   PULSE   | drive one DQS pulse
//   WAIT_RX | wait RX_LATENCY for feedback
//   SAMPLE  | accumulate RX_DATA_0[0]
//   DECIDE  | majority vote, phase update
//   STEP    | move one tap or give up at the last tap
//   DONE    | transition found
//   FAIL    | search exhausted or out of range
module pf_ddr4_dqsw_training_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int RX_LATENCY    = 4,
    parameter int SAMPLE_COUNT  = 8,
    parameter int MAX_TAPS      = 128
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    output logic       TRAIN_BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_FAIL,
    output logic [7:0] TAP_RESULT,
    output logic [1:0] TX_DATA_0,
    output logic [1:0] OE_DATA_0,
    input  logic [1:0] RX_DATA_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0
`ifdef PF_DDR4_DQSW_PULSE_CNT_EN
    ,
    output logic [15:0] PULSE_COUNT
`endif
);

    localparam int TMR_W = 16;
    localparam int CNT_W = $clog2(SAMPLE_COUNT + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RX_LD     = TMR_W'(RX_LATENCY - 1);
    localparam logic [CNT_W-1:0] SMP_N     = CNT_W'(SAMPLE_COUNT);
    localparam logic [CNT_W-1:0] SMP_HALF  = CNT_W'(SAMPLE_COUNT / 2);
    localparam logic [7:0]       LAST_TAP  = 8'(MAX_TAPS - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, SETTLE, PULSE, WAIT_RX, SAMPLE, DECIDE, STEP, DONE, FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         tap_q, tap_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic               phase_q, phase_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [7:0]         tres_q, tres_d;
    logic               busy_q, busy_d;
    logic [1:0]         tx_q, tx_d;
    logic [1:0]         oe_q, oe_d;
    logic               load_q, load_d;
    logic               move_q, move_d;
    logic               unused_rx;

    assign unused_rx = RX_DATA_0[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tap_d   = tap_q;
        ones_d  = ones_q;
        pcnt_d  = pcnt_q;
        phase_d = phase_q;
        done_d  = done_q;
        fail_d  = fail_q;
        tres_d  = tres_q;
        move_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (TRAIN_START) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    tap_d   = '0;
                    phase_d = 1'b0;
                    tres_d  = '0;
                    ones_d  = '0;
                    pcnt_d  = '0;
                end
            end
            LOAD: begin
                state_d = SETTLE;
                timer_d = SETTLE_LD;
            end
            SETTLE: begin
                if (timer_q == '0) state_d = PULSE;
                else               timer_d = timer_q - 1'b1;
            end
            PULSE: begin
                state_d = WAIT_RX;
                timer_d = RX_LD;
            end
            WAIT_RX: begin
                if (timer_q == '0) state_d = SAMPLE;
                else               timer_d = timer_q - 1'b1;
            end
            SAMPLE: begin
                ones_d  = ones_q + CNT_W'(RX_DATA_0[0]);
                pcnt_d  = pcnt_q + 1'b1;
                state_d = (pcnt_d < SMP_N) ? PULSE : DECIDE;
            end
            DECIDE: begin
                // A tie (ones == half) votes 0.
                if (!phase_q) begin
                    if (ones_q <= SMP_HALF) phase_d = 1'b1;
                    state_d = STEP;
                end else if (ones_q > SMP_HALF) begin
                    tres_d  = tap_q;
                    state_d = DONE;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (tap_q == LAST_TAP) begin
                    state_d = FAIL;
                end else begin
                    // The move pulse coincides with the first SETTLE cycle.
                    move_d  = 1'b1;
                    tap_d   = tap_q + 1'b1;
                    ones_d  = '0;
                    pcnt_d  = '0;
                    timer_d = SETTLE_LD;
                    state_d = SETTLE;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Range overflow overrides everything; FAIL is already terminal.
        if (DELAY_LINE_OUT_OF_RANGE_0 && state_q != IDLE && state_q != FAIL) begin
            state_d = FAIL;
            move_d  = 1'b0;
            tap_d   = tap_q;
        end

        if (state_d == DONE) done_d = 1'b1;
        if (state_d == FAIL) begin
            fail_d = 1'b1;
            tres_d = '0;
        end
        busy_d = (state_d != IDLE);
        tx_d   = (state_d == PULSE) ? 2'b01 : 2'b00;
        oe_d   = (state_d == PULSE) ? 2'b11 : 2'b00;
        load_d = (state_d == LOAD);
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            timer_q <= '0;
            tap_q   <= '0;
            ones_q  <= '0;
            pcnt_q  <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            tres_q  <= '0;
            busy_q  <= 1'b0;
            tx_q    <= '0;
            oe_q    <= '0;
            load_q  <= 1'b0;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tap_q   <= tap_d;
            ones_q  <= ones_d;
            pcnt_q  <= pcnt_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            tres_q  <= tres_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            load_q  <= load_d;
            move_q  <= move_d;
        end
    end

`ifdef PF_DDR4_DQSW_PULSE_CNT_EN
    logic [15:0] pcount_q, pcount_d;

    always_comb begin
        pcount_d = pcount_q;
        if (state_q == IDLE && TRAIN_START)
            pcount_d = '0;
        else if (state_q == PULSE && pcount_q != 16'hFFFF)
            pcount_d = pcount_q + 16'd1;
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) pcount_q <= '0;
        else       pcount_q <= pcount_d;
    end

    assign PULSE_COUNT = pcount_q;
`endif

    assign TRAIN_BUSY             = busy_q;
    assign TRAIN_DONE             = done_q;
    assign TRAIN_FAIL             = fail_q;
    assign TAP_RESULT             = tres_q;
    assign TX_DATA_0              = tx_q;
    assign OE_DATA_0              = oe_q;
    assign DELAY_LINE_LOAD_0      = load_q;
    assign DELAY_LINE_MOVE_0      = move_q;
    assign DELAY_LINE_DIRECTION_0 = 1'b0;

endmodule

// File: tb/tb_pf_ddr4_dqsw_training_ctrl.sv
// Bench for pf_ddr4_dqsw_training_ctrl. Two instances: index 0 uses default
// parameters (MAX_TAPS=128), index 1 uses MAX_TAPS=16. Each has an IOD model
// that tracks the delay-line tap from LOAD/MOVE pulses and returns, for the
// n-th DQS pulse at a tap, feedback 1 when n < k_tab[tap].
module tb_pf_ddr4_dqsw_training_ctrl;

    localparam int SC = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      start = '0;
    logic [1:0]      busy, done, fail, ld, mv, dir, oor;
    logic [1:0][7:0] tres;
    logic [1:0][1:0] tx, oe;
    logic [1:0][1:0] rx = '0;

    int tap_m[2]   = '{0, 0};
    int pidx[2]    = '{0, 0};
    int moves[2]   = '{0, 0};
    int pulses[2]  = '{0, 0};
    int loads[2]   = '{0, 0};
    int oor_tap[2] = '{-1, -1};
    int pat_err    = 0;
    int k_tab[2][256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign oor[0] = (oor_tap[0] >= 0) && (tap_m[0] == oor_tap[0]);
    assign oor[1] = (oor_tap[1] >= 0) && (tap_m[1] == oor_tap[1]);

    pf_ddr4_dqsw_training_ctrl u_dut_a (
        .FAB_CLK(clk), .RESET(rst), .TRAIN_START(start[0]),
        .TRAIN_BUSY(busy[0]), .TRAIN_DONE(done[0]), .TRAIN_FAIL(fail[0]),
        .TAP_RESULT(tres[0]), .TX_DATA_0(tx[0]), .OE_DATA_0(oe[0]),
        .RX_DATA_0(rx[0]), .DELAY_LINE_LOAD_0(ld[0]), .DELAY_LINE_MOVE_0(mv[0]),
        .DELAY_LINE_DIRECTION_0(dir[0]), .DELAY_LINE_OUT_OF_RANGE_0(oor[0])
    );

    pf_ddr4_dqsw_training_ctrl #(.MAX_TAPS(16)) u_dut_b (
        .FAB_CLK(clk), .RESET(rst), .TRAIN_START(start[1]),
        .TRAIN_BUSY(busy[1]), .TRAIN_DONE(done[1]), .TRAIN_FAIL(fail[1]),
        .TAP_RESULT(tres[1]), .TX_DATA_0(tx[1]), .OE_DATA_0(oe[1]),
        .RX_DATA_0(rx[1]), .DELAY_LINE_LOAD_0(ld[1]), .DELAY_LINE_MOVE_0(mv[1]),
        .DELAY_LINE_DIRECTION_0(dir[1]), .DELAY_LINE_OUT_OF_RANGE_0(oor[1])
    );

    // IOD model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld[i]) begin
                tap_m[i] = 0;
                pidx[i]  = 0;
                loads[i]++;
            end
            if (mv[i]) begin
                tap_m[i] = tap_m[i] + 1;
                pidx[i]  = 0;
                moves[i]++;
            end
            if (tx[i] == 2'b01) begin
                rx[i] = {1'b0, (pidx[i] < k_tab[i][tap_m[i] & 255])};
                pidx[i]++;
                pulses[i]++;
                if (oe[i] != 2'b11) pat_err++;
            end else if (tx[i] != 2'b00 || oe[i] != 2'b00) begin
                pat_err++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Tap search from the rules: first tap voting 1 after some tap voted 0.
    function automatic void ref_model(input int i, input int max_taps,
                                      output bit pass, output int res, output int mv_exp);
        bit seen0 = 1'b0;
        pass   = 1'b0;
        res    = 0;
        mv_exp = max_taps - 1;
        for (int t = 0; t < max_taps; t++) begin
            bit v = (k_tab[i][t] > SC / 2);
            if (seen0 && v) begin
                pass   = 1'b1;
                res    = t;
                mv_exp = t;
                return;
            end
            if (!v) seen0 = 1'b1;
        end
    endfunction

    task automatic fill(input int i, input int lo, input int hi, input int k);
        for (int t = lo; t <= hi; t++) k_tab[i][t] = k;
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string tag);
        int cyc = 0;
        while (busy[i] && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " busy_timeout"}, busy[i], 0);
    endtask

    task automatic run_train(input int i, input string tag, input int max_taps);
        bit pass;
        int res, mexp, m0, p0, l0;
        ref_model(i, max_taps, pass, res, mexp);
        m0 = moves[i];
        p0 = pulses[i];
        l0 = loads[i];
        pulse_start(i);
        check_val({tag, " busy"}, busy[i], 1);
        wait_idle(i, tag);
        check_val({tag, " done"}, done[i], pass);
        check_val({tag, " fail"}, fail[i], !pass);
        check_val({tag, " tap"}, tres[i], res);
        check_val({tag, " moves"}, moves[i] - m0, mexp);
        check_val({tag, " pulses"}, pulses[i] - p0, SC * (mexp + 1));
        check_val({tag, " loads"}, loads[i] - l0, 1);
        check_val({tag, " dir"}, dir[i], 0);
    endtask

    initial begin
        int m0, l0, cyc;
        fill(0, 0, 255, 0);
        fill(1, 0, 255, 0);

        // reset state
        #1;
        check_val("rst busy", busy, 0);
        check_val("rst flags", {done, fail}, 0);
        check_val("rst tap", tres, 0);
        check_val("rst tx_oe", {tx, oe}, 0);
        check_val("rst ld_mv", {ld, mv, dir}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle busy", busy, 0);

        // 0 for taps 0..9, 1 from tap 10
        fill(0, 0, 9, 0);
        fill(0, 10, 255, SC);
        run_train(0, "basic", 128);

        // 1 for 0..4, 0 for 5..19, 1 from 20
        fill(0, 0, 4, SC);
        fill(0, 5, 19, 0);
        fill(0, 20, 255, SC);
        run_train(0, "leading_ones", 128);

        // all zero on the 16-tap instance
        fill(1, 0, 255, 0);
        run_train(1, "exhaust", 16);

        // tie at tap 3 counts as 0, 5/8 from tap 4 counts as 1
        fill(0, 0, 2, SC);
        fill(0, 3, 3, 4);
        fill(0, 4, 255, 5);
        run_train(0, "tie", 128);

        // out of range at tap 6
        fill(0, 0, 255, 0);
        oor_tap[0] = 6;
        m0 = moves[0];
        pulse_start(0);
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (oor[0]) break;
        end
        check_val("oor seen", oor[0], 1);
        check_val("oor fail_next_edge", fail[0], 1);
        wait_idle(0, "oor");
        check_val("oor moves", moves[0] - m0, 6);
        check_val("oor done", done[0], 0);
        check_val("oor tap", tres[0], 0);
        oor_tap[0] = -1;

        // reset during WAIT_RX at tap 7
        fill(0, 0, 9, 0);
        fill(0, 10, 255, SC);
        pulse_start(0);
        cyc = 0;
        while (!(tap_m[0] == 7 && tx[0] == 2'b01) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("rst_mid reached", tap_m[0], 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_mid busy", busy[0], 0);
        check_val("rst_mid flags", {done[0], fail[0]}, 0);
        check_val("rst_mid tap", tres[0], 0);
        check_val("rst_mid tx_oe", {tx[0], oe[0]}, 0);
        check_val("rst_mid ld_mv", {ld[0], mv[0], dir[0]}, 0);
        m0 = moves[0];
        l0 = loads[0];
        repeat (6) @(negedge clk);
        check_val("rst_mid no_pulses", (moves[0] - m0) + (loads[0] - l0), 0);
        rst = 1'b0;
        @(negedge clk);
        run_train(0, "after_rst", 128);

        // start while busy is ignored
        pulse_start(1);
        repeat (20) @(negedge clk);
        l0 = loads[1];
        pulse_start(1);
        wait_idle(1, "restart_ignored");
        check_val("restart_ignored loads", loads[1] - l0, 0);

        // randomized patterns
        for (int r = 0; r < 8; r++) begin
            int i = r % 2;
            for (int t = 0; t < 256; t++)
                k_tab[i][t] = (t < 24) ? int'($urandom_range(0, SC)) : SC;
            run_train(i, $sformatf("rand%0d", r), (i == 0) ? 128 : 16);
        end

        check_val("tx_oe pattern", pat_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pf_ddr4_dqsw_training_ctrl.md
PF_DDR4_DQSW_TRAINING_CTRL -- requirements
Module: pf_ddr4_dqsw_training_ctrl

Interface
REQ-001 The block SHALL expose these parameters, one per line as name, default, meaning:
- SETTLE_CYCLES, 16: idle cycles after any delay-line load or move.
- RX_LATENCY, 4: cycles from DQS pulse to a valid RX_DATA sample.
- SAMPLE_COUNT, 8: DQS pulses per tap; power of two, range 2..64.
- MAX_TAPS, 128: delay-line taps searched, range 2..256.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- FAB_CLK, in, 1: the single fabric clock.
- RESET, in, 1: asynchronous, active-high reset.
- TRAIN_START, in, 1: one-cycle start pulse.
- TRAIN_BUSY, out, 1: high while training runs.
- TRAIN_DONE, out, 1: sticky pass flag.
- TRAIN_FAIL, out, 1: sticky fail flag.
- TAP_RESULT, out, 8: tap index of the 0->1 transition.
- TX_DATA_0, out, 2: DQS write pattern sent to the IOD.
- OE_DATA_0, out, 2: DQS output-enable pattern.
- RX_DATA_0, in, 2: DQ feedback from the IOD; bit 0 is used.
- DELAY_LINE_LOAD_0, out, 1: one-cycle pulse that restores tap 0.
- DELAY_LINE_MOVE_0, out, 1: one-cycle pulse that moves one tap.
- DELAY_LINE_DIRECTION_0, out, 1: held at 0 (increment).
- DELAY_LINE_OUT_OF_RANGE_0, in, 1: IOD range-overflow flag.

Function
REQ-003 The FSM states SHALL be IDLE, LOAD, SETTLE, PULSE, WAIT_RX, SAMPLE, DECIDE, STEP, DONE and FAIL.
REQ-004 In IDLE, a TRAIN_START pulse SHALL cause a move to LOAD on the next edge and SHALL clear TRAIN_DONE, TRAIN_FAIL, the tap counter and the phase flag.
REQ-005 In LOAD, the block SHALL hold DELAY_LINE_LOAD_0 high for exactly one cycle and then move to SETTLE.
REQ-006 SETTLE SHALL last SETTLE_CYCLES cycles and then move to PULSE.
REQ-007 PULSE SHALL last one cycle with TX_DATA_0=2'b01 and OE_DATA_0=2'b11; in every other state TX_DATA_0=2'b00 and OE_DATA_0=2'b00.
REQ-008 WAIT_RX SHALL last RX_LATENCY cycles; SAMPLE SHALL then add RX_DATA_0[0] into a ones-counter and increment a pulse counter.
REQ-009 After SAMPLE, if pulse counter < SAMPLE_COUNT the FSM SHALL return to PULSE; otherwise it SHALL go to DECIDE.
REQ-010 In DECIDE, the tap value SHALL be 1 when the ones-count > SAMPLE_COUNT/2, else 0; a tie SHALL count as 0.
REQ-011 While the phase flag is 0 (searching for a low tap), a value of 0 SHALL set the phase flag to 1, and the FSM SHALL then go to STEP.
REQ-012 While the phase flag is 1, a value of 1 SHALL latch TAP_RESULT = tap counter and the FSM SHALL go to DONE; a value of 0 SHALL send the FSM to STEP.
REQ-013 A tap that is already 0 on the first sample SHALL set the phase flag; the reported tap SHALL be the first 1 after at least one 0.
REQ-014 In STEP, if tap counter = MAX_TAPS-1 the FSM SHALL go to FAIL; otherwise it SHALL pulse DELAY_LINE_MOVE_0 for one cycle, increment the tap counter, clear the ones and pulse counters, and go to SETTLE.
REQ-015 DELAY_LINE_OUT_OF_RANGE_0 high in any non-IDLE state SHALL force FAIL on the next edge and take priority over all other transitions.
REQ-016 DONE and FAIL SHALL each set their sticky flag, drop TRAIN_BUSY and return to IDLE after one cycle.
REQ-017 TRAIN_START outside IDLE SHALL be ignored; TRAIN_BUSY SHALL be high in every state except IDLE.
REQ-018 TAP_RESULT SHALL hold its value until the next accepted TRAIN_START and SHALL read 0 after FAIL.

Reset
REQ-019 RESET high SHALL asynchronously force IDLE; all counters SHALL go to 0; all outputs SHALL go to 0, including TAP_RESULT=8'd0, TRAIN_DONE=0, TRAIN_FAIL=0 and DELAY_LINE_DIRECTION_0=0.
REQ-020 RESET asserted mid-training SHALL abort the run with no further LOAD or MOVE pulses; release SHALL be taken synchronously at the next FAB_CLK edge.

Configuration
REQ-021 With PF_DDR4_DQSW_PULSE_CNT_EN defined, the block SHALL add an output PULSE_COUNT[15:0] that counts PULSE cycles since the last accepted TRAIN_START, saturates at 16'hFFFF, and resets to 0.
REQ-022 With PF_DDR4_DQSW_PULSE_CNT_EN not defined, the PULSE_COUNT port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-023 The bench SHALL model feedback = 0 for taps 0..9 and 1 from tap 10, then pulse start -> TRAIN_DONE=1, TAP_RESULT=8'd10, exactly 10 MOVE pulses.
REQ-024 The bench SHALL model feedback = 1 for taps 0..4, 0 for taps 5..19 and 1 from tap 20 -> TAP_RESULT=8'd20.
REQ-025 The bench SHALL hold feedback at 0 for all taps with MAX_TAPS=16 -> TRAIN_FAIL=1, TAP_RESULT=0, 15 MOVE pulses.
REQ-026 The bench SHALL return feedback of 4 ones in 8 samples at tap 3 and 5 ones in 8 from tap 4 -> TAP_RESULT=8'd4 (tie resolves to 0).
REQ-027 The bench SHALL assert OUT_OF_RANGE at tap 6 -> TRAIN_FAIL=1 on the next edge, with no further MOVE pulses.
REQ-028 The bench SHALL assert RESET during WAIT_RX at tap 7 -> all outputs 0 immediately; a later start SHALL restart from LOAD and pass.
